// File: rtl/grom_pkg.sv
// grom_pkg: shared types and constants for the grom bus arbiter slice.
//   arb_state_t      : arbiter sequencer states
//   GROM_ADDR_W/DATA_W: default bus widths ({segment, offset} address, byte data)
//   ARB_CPU/ARB_DBG  : master index constants, also the bit positions in the
//                      two-bit request/grant vectors
package grom_pkg;

   localparam int GROM_ADDR_W = 12;
   localparam int GROM_DATA_W = 8;

   localparam logic ARB_CPU = 1'b0;
   localparam logic ARB_DBG = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/grom_arb_pick.sv
// grom_arb_pick: combinational winner selection for the two bus masters.
// Optional feature macro: GROM_ARB_RR_EN
//   defined   -> round-robin; on a tie the master that did not win last wins
//   undefined -> fixed priority, cpu wins every tie; no pointer input exists
// Ports:
//   req  in  [1:0] : request bits, indexed by ARB_CPU / ARB_DBG
//   last in        : last winner (round-robin build only)
//   gnt  out [1:0] : one-hot winner, all zero when nobody requests
module grom_arb_pick
   import grom_pkg::*;
(
   input  logic [1:0] req,
`ifdef GROM_ARB_RR_EN
   input  logic       last,
`endif
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
`ifdef GROM_ARB_RR_EN
      if (req[ARB_CPU] && req[ARB_DBG]) begin
         if (last == ARB_CPU) gnt[ARB_DBG] = 1'b1;
         else                 gnt[ARB_CPU] = 1'b1;
      end else begin
         gnt = req;
      end
`else
      if (req[ARB_CPU])      gnt[ARB_CPU] = 1'b1;
      else if (req[ARB_DBG]) gnt[ARB_DBG] = 1'b1;
`endif
   end

endmodule

// File: rtl/grom_bus_arbiter.sv
// grom_bus_arbiter: two-master arbiter/sequencer for the shared grom bus.
// Optional feature macro: GROM_ARB_RR_EN (round-robin tie break, see grom_arb_pick)
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   cpu_*/dbg_* req/addr/we/io/wdata : master commands, held until *_gnt
//   cpu_*/dbg_* gnt/done/rvalid : one-cycle response pulses
//   rdata                       : registered read data shared by both masters
//   mem_en/addr/wdata/we/ioreq  : registered bus command, one access at a time
//   mem_rdata                   : synchronous memory data, valid a cycle after sampling
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no access in flight; arbitrate and launch the winner's command
// ACCESS  | memory samples the command; writes complete here
// CAPTURE | read data on mem_rdata is registered into rdata
module grom_bus_arbiter
   import grom_pkg::*;
#(
   parameter int ADDR_W = GROM_ADDR_W,
   parameter int DATA_W = GROM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic              cpu_io,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic              dbg_we,
   input  logic              dbg_io,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic              cpu_rvalid,
   output logic              dbg_gnt,
   output logic              dbg_done,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_ioreq,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state, state_nxt;
   // Owner of the in-flight access; doubles as the round-robin pointer.
   // Resets to dbg so that the first tie goes to the cpu.
   logic              winner, winner_nxt;
   logic [1:0]        gnt_q, gnt_nxt;
   logic [1:0]        done_q, done_nxt;
   logic [1:0]        rvalid_q, rvalid_nxt;
   logic              mem_en_nxt, mem_we_nxt, mem_io_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt, rdata_nxt;
   logic [1:0]        pick_gnt;

   grom_arb_pick u_pick (
      .req  ({dbg_req, cpu_req}),
`ifdef GROM_ARB_RR_EN
      .last (winner),
`endif
      .gnt  (pick_gnt)
   );

   always_comb begin
      state_nxt     = state;
      winner_nxt    = winner;
      gnt_nxt       = 2'b00;
      done_nxt      = 2'b00;
      rvalid_nxt    = 2'b00;
      mem_en_nxt    = 1'b0;
      mem_we_nxt    = 1'b0;
      mem_io_nxt    = 1'b0;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      rdata_nxt     = rdata;
      case (state)
         IDLE: begin
            if (pick_gnt != 2'b00) begin
               winner_nxt = pick_gnt[ARB_DBG];
               gnt_nxt    = pick_gnt;
               mem_en_nxt = 1'b1;
               state_nxt  = ACCESS;
               if (pick_gnt[ARB_DBG]) begin
                  mem_addr_nxt  = dbg_addr;
                  mem_wdata_nxt = dbg_wdata;
                  mem_we_nxt    = dbg_we;
                  mem_io_nxt    = dbg_io;
               end else begin
                  mem_addr_nxt  = cpu_addr;
                  mem_wdata_nxt = cpu_wdata;
                  mem_we_nxt    = cpu_we;
                  mem_io_nxt    = cpu_io;
               end
            end
         end
         ACCESS: begin
            // mem_we still carries the launched command's direction here
            if (mem_we) begin
               done_nxt[winner] = 1'b1;
               state_nxt        = IDLE;
            end else begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            rdata_nxt          = mem_rdata;
            rvalid_nxt[winner] = 1'b1;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         winner    <= ARB_DBG;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         rvalid_q  <= 2'b00;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_ioreq <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
      end else begin
         state     <= state_nxt;
         winner    <= winner_nxt;
         gnt_q     <= gnt_nxt;
         done_q    <= done_nxt;
         rvalid_q  <= rvalid_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_ioreq <= mem_io_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         rdata     <= rdata_nxt;
      end
   end

   assign cpu_gnt    = gnt_q[ARB_CPU];
   assign dbg_gnt    = gnt_q[ARB_DBG];
   assign cpu_done   = done_q[ARB_CPU];
   assign dbg_done   = done_q[ARB_DBG];
   assign cpu_rvalid = rvalid_q[ARB_CPU];
   assign dbg_rvalid = rvalid_q[ARB_DBG];

endmodule

// File: tb/tb_grom_bus_arbiter.sv
// Testbench for grom_bus_arbiter. A transaction-level model decides, from the
// request inputs it sees each cycle, which master wins and when the bus frees,
// and queues the expected gnt/done/rvalid pulses; a monitor pops and compares.
module tb_grom_bus_arbiter;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0, cpu_io = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_io = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic [DW-1:0] dbg_wdata = '0;
   logic          cpu_gnt, cpu_done, cpu_rvalid, dbg_gnt, dbg_done, dbg_rvalid;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_en, mem_we, mem_ioreq;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   grom_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_io(cpu_io), .cpu_wdata(cpu_wdata),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_io(dbg_io), .dbg_wdata(dbg_wdata),
      .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rvalid(cpu_rvalid),
      .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rvalid(dbg_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_ioreq(mem_ioreq), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // synchronous RAM + I/O space, indexed by {io, addr}
   logic [DW-1:0] ram [0:8191];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[{mem_ioreq, mem_addr}] <= mem_wdata;
         else        mem_rdata <= ram[{mem_ioreq, mem_addr}];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   // pulse vector layout: {dbg_rvalid, cpu_rvalid, dbg_done, cpu_done, dbg_gnt, cpu_gnt}
   typedef struct {
      int            cyc;
      logic [5:0]    vec;
      logic          is_gnt;
      logic          we;
      logic          io;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          chk_data;
   } ev_t;

   ev_t           evq[$];
   ev_t           m_e, m_n;
   int            free_cyc = 0;
   logic          last_win = 1'b1;
   logic [DW-1:0] ref_mem [int];
   logic [5:0]    m_act, m_exp;
   logic          m_w, m_we, m_io, m_has;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd;
   int            m_key;

   initial forever begin
      @(negedge clk);
      cyc++;
      m_act = {dbg_rvalid, cpu_rvalid, dbg_done, cpu_done, dbg_gnt, cpu_gnt};
      m_exp = 6'b0;
      m_has = 1'b0;
      if (evq.size() != 0 && evq[0].cyc == cyc) begin
         m_e   = evq.pop_front();
         m_exp = m_e.vec;
         m_has = 1'b1;
      end
      chk("pulses", 32'(m_act), 32'(m_exp));
      if (m_has && m_e.is_gnt) begin
         chk("mem_cmd", 32'({mem_addr, mem_we, mem_ioreq}), 32'({m_e.addr, m_e.we, m_e.io}));
         if (m_e.we) chk("mem_wdata", 32'(mem_wdata), 32'(m_e.data));
      end
      if (m_has && m_e.is_gnt)
         chk("mem_en", 32'(mem_en), 32'd1);
      else
         chk("mem_strobes_idle", 32'({mem_en, mem_we, mem_ioreq}), 32'd0);
      if (m_has && !m_e.is_gnt && !m_e.we && m_e.chk_data)
         chk("rdata", 32'(rdata), 32'(m_e.data));

      // model: decide what the inputs seen this cycle lead to
      if (reset) begin
         while (evq.size() != 0 && evq[$].cyc > cyc) void'(evq.pop_back());
         free_cyc = cyc + 1;
         last_win = 1'b1;
      end else if (cyc >= free_cyc && (cpu_req || dbg_req)) begin
         if (cpu_req && dbg_req) begin
`ifdef GROM_ARB_RR_EN
            m_w = ~last_win;
`else
            m_w = 1'b0;
`endif
         end else begin
            m_w = dbg_req;
         end
         last_win = m_w;
         m_we   = m_w ? dbg_we    : cpu_we;
         m_io   = m_w ? dbg_io    : cpu_io;
         m_addr = m_w ? dbg_addr  : cpu_addr;
         m_wd   = m_w ? dbg_wdata : cpu_wdata;
         m_key  = int'({m_io, m_addr});
         m_n.cyc = cyc + 1; m_n.vec = 6'b000001 << m_w; m_n.is_gnt = 1'b1;
         m_n.we = m_we; m_n.io = m_io; m_n.addr = m_addr; m_n.data = m_wd; m_n.chk_data = 1'b0;
         evq.push_back(m_n);
         m_n.is_gnt = 1'b0;
         if (m_we) begin
            ref_mem[m_key] = m_wd;
            m_n.cyc = cyc + 2; m_n.vec = 6'b000100 << m_w;
            free_cyc = cyc + 2;
         end else begin
            m_n.chk_data = (ref_mem.exists(m_key) != 0);
            m_n.data     = m_n.chk_data ? ref_mem[m_key] : '0;
            m_n.cyc = cyc + 3; m_n.vec = 6'b010000 << m_w;
            free_cyc = cyc + 3;
         end
         evq.push_back(m_n);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(); @(posedge clk); #1; endtask
   task automatic samp(); @(negedge clk); endtask

   task automatic drive(input int m, input logic req, input logic we, input logic io,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (m == 0) begin
         cpu_req = req; cpu_we = we; cpu_io = io; cpu_addr = a; cpu_wdata = d;
      end else begin
         dbg_req = req; dbg_we = we; dbg_io = io; dbg_addr = a; dbg_wdata = d;
      end
   endtask

   logic g [0:31];
   int   ng;
   logic [1:0] pg;
   logic [AW-1:0] ra;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      samp();
      chk("reset_pulses_strobes", 32'({cpu_gnt, dbg_gnt, cpu_done, dbg_done, cpu_rvalid, dbg_rvalid,
                                        mem_en, mem_we, mem_ioreq}), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_wdata_rdata", 32'({mem_wdata, rdata}), 32'd0);

      // cpu write 0xA5 -> 0xD10
      tick(); drive(0, 1'b1, 1'b1, 1'b0, 12'hD10, 8'hA5);
      tick(); cpu_req = 1'b0;
      samp();
      chk("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
      chk("wr_cmd", 32'({mem_addr, mem_we, mem_wdata}), 32'({12'hD10, 1'b1, 8'hA5}));
      tick(); samp();
      chk("wr_cpu_done", 32'({cpu_done, mem_we}), 32'({1'b1, 1'b0}));
      repeat (2) tick();

      // dbg read 0xD10 -> 0xA5
      drive(1, 1'b1, 1'b0, 1'b0, 12'hD10, 8'h00);
      tick(); dbg_req = 1'b0;
      samp(); chk("rd_dbg_gnt", 32'(dbg_gnt), 32'd1);
      tick(); tick(); samp();
      chk("rd_dbg_rvalid", 32'({dbg_rvalid, cpu_rvalid}), 32'({1'b1, 1'b0}));
      chk("rd_rdata", 32'(rdata), 32'hA5);
      repeat (2) tick();

      // cpu I/O write to port 0x03
      drive(0, 1'b1, 1'b1, 1'b1, 12'h003, 8'h5A);
      samp(); chk("io_before", 32'(mem_ioreq), 32'd0);
      tick(); cpu_req = 1'b0;
      samp(); chk("io_cmd", 32'({mem_ioreq, mem_addr}), 32'({1'b1, 12'h003}));
      tick(); samp(); chk("io_after", 32'(mem_ioreq), 32'd0);
      repeat (2) tick();

      // both masters reading continuously
      drive(0, 1'b1, 1'b0, 1'b0, 12'hD10, 8'h00);
      drive(1, 1'b1, 1'b0, 1'b0, 12'hD10, 8'h00);
      ng = 0;
      for (int i = 0; i < 24; i++) begin
         samp();
         if ((cpu_gnt || dbg_gnt) && ng < 32) begin g[ng] = dbg_gnt; ng++; end
         tick();
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      chk("cont_grant_count", 32'(ng), 32'd8);
`ifdef GROM_ARB_RR_EN
      chk("rr_first_dbg", 32'(g[0]), 32'd1);
      for (int i = 1; i < ng; i++) chk("rr_alternate", 32'(g[i]), 32'(~g[i-1]));
`else
      for (int i = 0; i < ng; i++) chk("fixed_cpu_wins", 32'(g[i]), 32'd0);
`endif
      repeat (6) tick();

      // reset during the ACCESS cycle of a dbg read
      drive(1, 1'b1, 1'b0, 1'b0, 12'hD10, 8'h00);
      tick(); dbg_req = 1'b0; reset = 1'b1;
      samp(); chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd1);
      tick(); reset = 1'b0;
      samp(); chk("rst_mem_off", 32'({mem_en, mem_we, dbg_rvalid}), 32'd0);
      tick(); drive(0, 1'b1, 1'b0, 1'b0, 12'hD10, 8'h00);
      samp(); chk("rst_no_early_gnt", 32'({cpu_gnt, dbg_rvalid}), 32'd0);
      tick(); cpu_req = 1'b0;
      samp(); chk("rst_cpu_gnt", 32'({cpu_gnt, dbg_rvalid}), 32'({1'b1, 1'b0}));
      for (int i = 0; i < 4; i++) begin
         tick(); samp(); chk("rst_no_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      end

      // randomized traffic
      pg = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         tick();
         for (int m = 0; m < 2; m++) begin
            if (pg[m] || !((m == 0) ? cpu_req : dbg_req)) begin
               ra = 12'hD00 | 12'($urandom_range(0, 7));
               if ($urandom_range(0, 99) < 45)
                  drive(m, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                        ra, 8'($urandom));
               else
                  drive(m, 1'b0, 1'b0, 1'b0, ra, 8'h00);
            end
         end
         samp();
         pg = {dbg_gnt, cpu_gnt};
      end
      tick(); cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (8) tick();
      samp();
      chk("queue_drained", 32'(evq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/grom_bus_arbiter.md
# grom_bus_arbiter

Two-master arbiter and sequencer for the single shared grom memory/I-O bus (12-bit address, 8-bit data, `we`, `ioreq`). Sits between the grom CPU bus adapter (master 0, `cpu_*`) and the debug/program loader (master 1, `dbg_*`) on one side, and the synchronous RAM plus I/O port decode on the other. It serialises accesses with a request/grant handshake, drives the memory strobes for exactly one access at a time and returns write completion or read data to the winning master.

## Interface
- `ADDR_W`, default 12, address width (`{segment, offset}`).
- `DATA_W`, default 8, data width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` / `dbg_req` in 1: access request; held with its command until the matching `*_gnt` is seen.
- `cpu_addr` / `dbg_addr` in ADDR_W: access address.
- `cpu_we` / `dbg_we` in 1: 1 = write, 0 = read.
- `cpu_io` / `dbg_io` in 1: 1 = I/O-space access (drives `mem_ioreq`).
- `cpu_wdata` / `dbg_wdata` in DATA_W: write data.
- `cpu_gnt` / `dbg_gnt` out 1: one-cycle pulse; command accepted.
- `cpu_done` / `dbg_done` out 1: one-cycle pulse; write completed.
- `cpu_rvalid` / `dbg_rvalid` out 1: one-cycle pulse; `rdata` valid for this master.
- `rdata` out DATA_W: registered read data, shared by both masters.
- `mem_en` out 1: access strobe to memory/I-O decode.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_we` out 1, `mem_ioreq` out 1: registered bus command.
- `mem_rdata` in DATA_W: synchronous memory read data, valid the cycle after the address is sampled.

## Operation
- States: IDLE, ACCESS, CAPTURE.
- IDLE: if any `*_req` is high, pick a winner (see Configuration), register its addr/wdata/we/io onto `mem_*`, set `mem_en`, pulse the winner's `gnt`, and go to ACCESS. Otherwise stay in IDLE with `mem_en`=0 and `mem_we`=0.
- ACCESS: memory samples the command this cycle. At the edge, `mem_en`, `mem_we` and `mem_ioreq` are cleared.
  - Write: pulse the winner's `done` and go to IDLE.
  - Read: go to CAPTURE.
- CAPTURE: at the edge, `rdata` <= `mem_rdata`, pulse the winner's `rvalid`, and go to IDLE.
- A master may change or drop `req` and its command in the cycle after `gnt`. A `req` still high after its `gnt` is a new request.
- A request arriving in ACCESS or CAPTURE waits; it is evaluated in the next IDLE cycle.
- `mem_addr`, `mem_wdata` and `rdata` hold their last value when idle.
- The arbiter never issues two accesses concurrently and never grants both masters in one cycle.

## Timing
- Reset values: state IDLE; all `gnt`/`done`/`rvalid` 0; `mem_en`, `mem_we`, `mem_ioreq` 0; `mem_addr`, `mem_wdata`, `rdata` 0; round-robin pointer favours cpu.
- Request seen in IDLE at cycle 0:
  - `gnt` and `mem_*` are valid in cycle 1.
  - Write: `done` in cycle 2. The arbiter is IDLE in cycle 2, so the next grant can come in cycle 3. Write throughput is one access per 2 cycles.
  - Read: `rvalid` and `rdata` in cycle 3. The arbiter is IDLE in cycle 3. Read throughput is one access per 3 cycles.
- Reset mid-access: the in-flight access is abandoned. `mem_we`/`mem_en` are 0 from the next cycle, and no `done`/`rvalid` is produced for it.
- Both masters requesting in the same IDLE cycle: exactly one `gnt`. The loser stays pending.

## Configuration
- `GROM_ARB_RR_EN` defined: round-robin. A one-bit pointer records the last winner. On a tie, the other master wins. A sole requester always wins.
- Not defined: fixed priority, cpu always wins ties, and the pointer is not built. dbg can starve while the CPU requests continuously. This is the intended default: the loader runs with the CPU halted (`hlt`).

## Structure
- Shared package `grom_pkg`:
  - state enum `arb_state_t` (IDLE, ACCESS, CAPTURE);
  - `GROM_ADDR_W`=12, `GROM_DATA_W`=8;
  - master index constants `ARB_CPU`=0, `ARB_DBG`=1.
- One sub-module, `grom_arb_pick`:
  - combinational winner selection from the two `req` bits plus the pointer;
  - outputs a one-hot grant vector;
  - holds the `GROM_ARB_RR_EN` conditional logic.
- The top level holds the FSM, command registers and response pulses.

## Test plan
- cpu write 0xA5 to 0x0D10 from IDLE -> cycle 1: `cpu_gnt`=1, `mem_addr`=0xD10, `mem_we`=1, `mem_wdata`=0xA5. Cycle 2: `cpu_done`=1, `mem_we`=0.
- dbg read of 0x0D10 with memory returning 0xA5 -> `dbg_gnt` in cycle 1, `dbg_rvalid`=1 with `rdata`=0xA5 in cycle 3. `cpu_rvalid` stays 0.
- cpu I/O write to port 0x03 (`cpu_io`=1) -> `mem_ioreq`=1 and `mem_addr`=0x003 for exactly one cycle.
- Both masters reading continuously:
  - with `GROM_ARB_RR_EN`, grants alternate cpu, dbg, cpu, …;
  - without it, all grants go to cpu and `dbg_gnt` stays 0.
- `reset` asserted in the ACCESS cycle of a dbg read -> no `dbg_rvalid`. Next cycle: `mem_en`=0 and state IDLE. A cpu request one cycle after reset releases gets `cpu_gnt` on the following cycle.
